serpent_key_schedule: RTL
=========================

SERPENT_KEY_SCHEDULE -- requirements
Module: serpent_key_schedule

Interface
REQ-001 SHALL have parameter ROUNDS, default 32: cipher rounds; the subkey store holds ROUNDS+1 entries of 128 bits.
REQ-002 SHALL have i_clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have i_rstn  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have i_start  input  1: one-cycle pulse that begins expansion of i_key.
REQ-005 SHALL have i_key  input  256: user key; word k = i_key[32k+31:32k].
REQ-006 SHALL have i_address  input  6: subkey index, driven by the encryptor's round counter.
REQ-007 SHALL have o_subkey  output  128: subkey selected by i_address, combinational read.
REQ-008 SHALL have o_subkey_valid  output  1: high while the whole subkey store is complete and unchanged.
REQ-009 SHALL have o_busy  output  1: high while expansion is in progress.

Function
REQ-010 SHALL implement states IDLE, EXPAND and READY.
REQ-011 SHALL, on i_start in IDLE or READY, latch i_key into an 8-word window, clear the word counter i, drop o_subkey_valid on the next edge, and enter EXPAND.
REQ-012 SHALL load the window as prekey words w[-8..-1], with w[-8] = i_key[31:0] and w[-1] = i_key[255:224].
REQ-013 SHALL, in EXPAND, compute one word per cycle: w[i] = ROL11(w[i-8]^w[i-5]^w[i-3]^w[i-1]^0x9E3779B9^i).
  - i is a 32-bit zero-extended counter running 0..4*ROUNDS+3 (0..131 by default).
  - The window shifts by one word per cycle.
REQ-014 SHALL, on each cycle where i mod 4 = 3, form group j = i/4 from w[4j..4j+3] and apply S-box S[(3-j) mod 8] bitsliced, then write subkey j in that same cycle.
  - For each bit b in 0..31, the S-box input nibble is {w[4j+3][b], w[4j+2][b], w[4j+1][b], w[4j][b]}.
  - Output nibble bit n goes to bit b of word n.
  - Subkey j is stored as {K3,K2,K1,K0}, with K0 in bits [31:0].
REQ-015 SHALL use the standard Serpent S0..S7 tables; no initial or final permutation is applied.
REQ-016 SHALL enter READY after the final word (i = 4*ROUNDS+3) is written.
  - o_subkey_valid rises on the same edge.
  - With i_start sampled high at edge N, o_subkey_valid is first high after edge N+132 (default ROUNDS).
REQ-017 SHALL drive o_busy high exactly while in EXPAND.
REQ-018 SHALL ignore i_start while in EXPAND; the expansion in progress completes unchanged.
REQ-019 SHALL drive o_subkey to all-zero when o_subkey_valid is low or i_address > ROUNDS; otherwise it drives the stored subkey[i_address].
REQ-020 SHALL hold the subkey store unchanged in READY regardless of i_key changes until the next accepted i_start.

Reset
REQ-021 SHALL, on i_rstn low and at any time including mid-EXPAND:
  - go to IDLE;
  - clear o_subkey_valid, o_busy, the word counter and the window;
  - force o_subkey to zero.
REQ-022 SHALL leave the subkey store contents unreset; they are unobservable until a complete expansion sets o_subkey_valid.
REQ-023 SHALL require a new i_start after reset release before o_subkey_valid can rise.

Configuration
REQ-024 SHALL support macro SERPENT_SHORT_KEY_EN.
  - When defined: adds input i_key_len (2 bits: 00 = 128, 01 = 192, 10 or 11 = 256).
  - For a short key, bits above the key length are replaced with a single 1 at bit position len, then zeros, before latching. Key bits at and above len are ignored.
  - When undefined: no i_key_len port, and i_key is used verbatim as 256 bits.

Verification
REQ-025 SHALL cover these directed scenarios:
  - Reset, then i_start with i_key = 0: first generated word w[0] = 0xBBCDCCF1; o_subkey_valid is high exactly 132 edges after the start edge; all 33 subkeys match a software Serpent key schedule for the zero key.
  - READY with i_address = 33 and i_address = 63: o_subkey = 0; i_address = 0..32 returns the model values.
  - Second i_start in EXPAND at cycle 50: ignored, and completion time is unchanged. i_start in READY with a new key: o_subkey_valid low the next cycle and high 132 cycles later with the new subkeys.
  - i_rstn low at cycle 70 of EXPAND: o_busy = 0, o_subkey_valid = 0, o_subkey = 0. No valid occurs without a new i_start.
  - With SERPENT_SHORT_KEY_EN, i_key_len = 00 and i_key low 128 bits zero (upper bits random): subkeys equal those of a 256-bit key with only bit 128 set.

Source files
------------

// File: rtl/serpent_key_schedule.sv
// Serpent key schedule: expands a 256-bit user key into ROUNDS+1 128-bit
// subkeys, one prekey word per clock, and serves them through a
// combinational read port indexed by the encryptor's round counter.
// Optional feature: define SERPENT_SHORT_KEY_EN to add i_key_len and pad
// 128/192-bit keys before they are latched.
module serpent_key_schedule #(
  parameter int ROUNDS = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
`ifdef SERPENT_SHORT_KEY_EN
  input  logic [1:0]   i_key_len,
`endif
  input  logic [255:0] i_key,
  input  logic [5:0]   i_address,
  output logic [127:0] o_subkey,
  output logic         o_subkey_valid,
  output logic         o_busy
);

  localparam int          LAST = 4 * ROUNDS + 3;
  localparam int          CW   = $clog2(LAST + 1);
  localparam logic [31:0] PHI  = 32'h9E37_79B9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Standard Serpent S-boxes S0..S7, indexed [box][input nibble].
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   win [8];          // win[0] = w[i-8] ... win[7] = w[i-1]
  logic          valid;
  logic [127:0]  subkeys [ROUNDS+1];

  logic [255:0]  key_in;
  logic [31:0]   mix;
  logic [31:0]   new_word;
  logic [2:0]    box_sel;
  logic [127:0]  sbox_out;
  logic [CW-3:0] group;

  // Key conditioning: short keys get a single 1 just above their length.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    key_in = i_key;
`ifdef SERPENT_SHORT_KEY_EN
    case (i_key_len)
      2'b00:   key_in = {127'b0, 1'b1, i_key[127:0]};
      2'b01:   key_in = {63'b0, 1'b1, i_key[191:0]};
      default: key_in = i_key;
    endcase
`endif
  end

  // Next prekey word and the bitsliced S-box over the group it completes.
  always_comb begin
    mix      = win[0] ^ win[3] ^ win[5] ^ win[7] ^ PHI ^ 32'(cnt);
    new_word = {mix[20:0], mix[31:21]};
    group    = cnt[CW-1:2];
    box_sel  = 3'd3 - group[2:0];
    sbox_out = '0;
    for (int b = 0; b < 32; b++) begin
      logic [3:0] nib;
      nib = SBOX[box_sel][{new_word[b], win[7][b], win[6][b], win[5][b]}];
      for (int n = 0; n < 4; n++) sbox_out[32*n + b] = nib[n];
    end
  end

  // Control FSM, prekey window and word counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (i_start) begin
            for (int k = 0; k < 8; k++) win[k] <= key_in[32*k +: 32];
            cnt   <= '0;
            valid <= 1'b0;
            state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          for (int k = 0; k < 7; k++) win[k] <= win[k+1];
          win[7] <= new_word;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(LAST)) begin
            state <= ST_READY;
            valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Subkey store write on every fourth word.
  // NOTE: the store is deliberately not reset; valid gates every read until a full expansion refills it.
  always_ff @(posedge i_clk) begin
    if (state == ST_EXPAND && cnt[1:0] == 2'b11) subkeys[group] <= sbox_out;
  end

  assign o_busy         = (state == ST_EXPAND);
  assign o_subkey_valid = valid;

  // Combinational read, zero whenever the store is stale or the index is out of range.
  always_comb begin
    o_subkey = '0;
    if (valid && (32'(i_address) <= ROUNDS)) o_subkey = subkeys[i_address];
  end

endmodule
